serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 158 +++++++++++++++
 tb/tb_serial_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit add/subtract unit for the 18-bit CPU datapath.
//   One result bit is produced per clock, LSB first. A single full-add cell
//   (two half_adder instances plus an OR) is reused for every bit. The carry
//   is held in a flip-flop between bits.
//
//   Subtraction is a + ~b + 1. The operand B is inverted at capture and the
//   carry flip-flop is preloaded with 1.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous reset, active-high
//     start      request a new operation (accepted in IDLE or DONE)
//     sub        0 = a+b, 1 = a-b; captured with start
//     a, b       WIDTH-bit operands; captured with start
//     busy       high while bits are being processed (RUN)
//     done       one-cycle pulse; sum/carry_out are valid
//     sum        result; held until the next accepted start
//     carry_out  final carry; for subtraction 1 = no borrow
//     overflow   signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the overflow output.
// -----------------------------------------------------------------------------

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             c_ff;
   logic [CNT_W-1:0] cnt;

   // Full-add cell: the first half adder combines the operand bits. The second
   // half adder folds in the stored carry.
   logic ha0_s, ha0_c;
   logic s_bit, ha1_c;
   logic c_next;

   half_adder u_ha0 (
      .x (a_sh[0]),
      .y (b_sh[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   half_adder u_ha1 (
      .x (ha0_s),
      .y (c_ff),
      .s (s_bit),
      .c (ha1_c)
   );

   assign c_next = ha0_c | ha1_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         c_ff      <= 1'b0;
         cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         overflow  <= 1'b0;
`endif
      end else begin
         case (state)
            // IDLE and DONE accept start identically. Done is cleared on
            // leaving DONE regardless of start.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh      <= a;
                  b_sh      <= sub ? ~b : b;
                  c_ff      <= sub;
                  cnt       <= '0;
                  sum       <= '0;
                  carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                  overflow  <= 1'b0;
`endif
                  busy      <= 1'b1;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            // start is deliberately not looked at here. An in-flight
            // operation cannot be disturbed.
            RUN: begin
               sum  <= {s_bit, sum[WIDTH-1:1]};
               a_sh <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               c_ff <= c_next;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  carry_out <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                  // Carry into the MSB differs from the carry out of it.
                  overflow  <= c_ff ^ c_next;
`endif
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder. The stimulus pushes the reference
//   model's result for every accepted start. A monitor pops and compares
//   on each done pulse.
// -----------------------------------------------------------------------------

module tb_serial_adder;

   localparam int  W = 18;
   localparam longint M = longint'(1) << W;

   typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic         overflow;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   exp_t sb_q[$];
   exp_t last_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", name, act, req);
   endtask

   // Reference model: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t   e;
      longint ux, uy, sx, sy, r, sr;
      ux = longint'(x);
      uy = longint'(y);
      sx = (ux >= M / 2) ? ux - M : ux;
      sy = (uy >= M / 2) ? uy - M : uy;
      if (s) begin
         r    = ux - uy;
         sr   = sx - sy;
         e.co = (ux >= uy);
      end else begin
         r    = ux + uy;
         sr   = sx + sy;
         e.co = (r >= M);
      end
      r    = r & (M - 1);
      e.s  = r[W-1:0];
      e.ov = (sr > M / 2 - 1) || (sr < -(M / 2));
      return e;
   endfunction

   // Monitor: compares every done pulse against the oldest pending result.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done_prev) check("done_single_cycle", {31'd0, done}, 32'd0);
      if (!rst && done) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL done_unexpected: actual done=1 required done=0 (no pending op)");
         end else begin
            e = sb_q.pop_front();
            check("sum", {14'd0, sum}, {14'd0, e.s});
            check("carry_out", {31'd0, carry_out}, {31'd0, e.co});
`ifdef SERIAL_ADDER_OVF_EN
            check("overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
            check("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
      done_prev = done;
   end

   // Called at a negedge: presents one start pulse. Returns at the negedge
   // right after the capture edge.
   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
      last_exp = model(x, y, s);
      sb_q.push_back(last_exp);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done. n0 is how many negedges past capture we are.
   task automatic wait_done(input int n0);
      int n;
      int busy_cnt;
      n = n0;
      busy_cnt = 0;
      while (!done && n < W + 10) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      check("latency", n, W);
      check("busy_cycles", busy_cnt, W - n0);
   endtask

   task automatic hold_check();
      repeat (3) @(negedge clk);
      check("sum_hold", {14'd0, sum}, {14'd0, last_exp.s});
      check("carry_hold", {31'd0, carry_out}, {31'd0, last_exp.co});
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      drive(x, y, s);
      wait_done(0);
      hold_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      rst   = 1'b1;
      start = 1'b1;
      sub   = 1'b0;
      a     = 18'h2AAAA;
      b     = 18'h15555;

      // Reset held with start asserted.
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {14'd0, sum}, 32'd0);
      check("rst_carry", {31'd0, carry_out}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
      start = 1'b0;
      rst   = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst", {31'd0, busy}, 32'd0);
      check("idle_no_done", done_cnt, 0);

      // Directed arithmetic, wrap and borrow cases.
      @(negedge clk);
      run_op(18'h00005, 18'h00003, 1'b0);
      run_op(18'h3FFFF, 18'h00001, 1'b0);
      run_op(18'h00005, 18'h00007, 1'b1);
      run_op(18'h00007, 18'h00005, 1'b1);
      run_op(18'h1FFFF, 18'h00001, 1'b0);
      run_op(18'h20000, 18'h00001, 1'b1);
      run_op(18'h00005, 18'h00003, 1'b0);
      run_op(18'h12345, 18'h12345, 1'b1);

      // start during RUN is ignored.
      drive(18'h00010, 18'h00020, 1'b0);
      repeat (5) @(negedge clk);
      a = 18'h3FFFF;
      b = 18'h3FFFF;
      sub = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6);
      hold_check();

      // Reset in the middle of an operation: outputs clear, no done.
      d0 = done_cnt;
      drive(18'h00010, 18'h00020, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_sum", {14'd0, sum}, 32'd0);
      check("abort_carry", {31'd0, carry_out}, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (W + 5) @(negedge clk);
      check("abort_no_done", done_cnt, d0);

      // Back-to-back: start presented during the DONE cycle.
      drive(18'h00100, 18'h00200, 1'b0);
      wait_done(0);
      drive(18'h00001, 18'h00001, 1'b0);
      wait_done(0);
      hold_check();
      check("b2b_sum", {14'd0, sum}, 32'h00002);

      // Randomized operations, mixing idle gaps and back-to-back starts.
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(0, (1 << W) - 1));
         if (i % 6 == 0) ra = 18'h3FFFF;
         if (i % 6 == 3) rb = 18'h20000;
         drive(ra, rb, 1'(($urandom_range(0, 1))));
         wait_done(0);
         if ($urandom_range(0, 1) == 1) hold_check();
      end
      hold_check();

      check("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
